// File: rtl/sensor_fifo_pkg.sv
// rtl/sensor_fifo_pkg.sv - shared widths and types for the sensor sample FIFO
package sensor_fifo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 8;
    localparam int ADDR_W     = $clog2(DEPTH);

    typedef logic [DATA_WIDTH-1:0] sample_t;
    // One spare MSB over the address distinguishes full from empty when addresses match.
    typedef logic [ADDR_W:0]       fifo_ptr_t;

endpackage

// File: rtl/sensor_fifo_ptr.sv
// rtl/sensor_fifo_ptr.sv - wrap-bit pointer used for both write and read sides
module sensor_fifo_ptr
    import sensor_fifo_pkg::*;
(
    input  logic      clk,
    input  logic      n_rst,
    input  logic      inc,
    output fifo_ptr_t ptr
);

    // Natural overflow of the ADDR_W+1 bit counter gives the mod 2*DEPTH wrap.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_fifo_storage.sv
// rtl/sensor_fifo_storage.sv - FWFT sensor sample FIFO; SENSOR_FIFO_LEVEL_EN adds fifo_level
module sensor_fifo_storage
    import sensor_fifo_pkg::*;
(
    input  logic    clk,
    input  logic    n_rst,
    input  logic    write_command,
    input  sample_t write_data,
    input  logic    read_command,
    output sample_t read_data,
    output logic    fifo_empty,
    output logic    fifo_full
`ifdef SENSOR_FIFO_LEVEL_EN
    ,
    output fifo_ptr_t fifo_level
`endif
);

    fifo_ptr_t wptr;
    fifo_ptr_t rptr;
    sample_t   mem [DEPTH];
    logic      wr_en;
    logic      rd_en;

    // Full blocks the write and empty blocks the read, so a simultaneous pair
    // at either boundary degrades to a single accepted operation.
    assign wr_en = write_command && !fifo_full;
    assign rd_en = read_command  && !fifo_empty;

    sensor_fifo_ptr u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (wr_en),
        .ptr   (wptr)
    );

    sensor_fifo_ptr u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (rd_en),
        .ptr   (rptr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wptr[ADDR_W-1:0]] <= write_data;
        end
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                        (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

    // Head word falls through with no read latency; forced to zero when nothing is stored.
    assign read_data = fifo_empty ? '0 : mem[rptr[ADDR_W-1:0]];

`ifdef SENSOR_FIFO_LEVEL_EN
    assign fifo_level = wptr - rptr;
`endif

endmodule

// File: tb/tb_sensor_fifo_storage.sv
// tb/tb_sensor_fifo_storage.sv - self-checking bench for sensor_fifo_storage
module tb_sensor_fifo_storage;

    localparam int D = 8;

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic        write_command;
    logic [31:0] write_data;
    logic        read_command;
    logic [31:0] read_data;
    logic        fifo_empty;
    logic        fifo_full;
`ifdef SENSOR_FIFO_LEVEL_EN
    logic [3:0]  fifo_level;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_q[$];

    typedef struct {
        bit          wr;
        logic [31:0] d;
        bit          rd;
        logic [31:0] exp_data;
        bit          exp_empty;
        bit          exp_full;
    } vec_t;

    vec_t tbl[$];

    always #5 tb_clk = ~tb_clk;

    sensor_fifo_storage dut (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .write_command (write_command),
        .write_data    (write_data),
        .read_command  (read_command),
        .read_data     (read_data),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full)
`ifdef SENSOR_FIFO_LEVEL_EN
        ,
        .fifo_level    (fifo_level)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_head();
        return (model_q.size() == 0) ? 32'h0 : model_q[0];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " read_data"}, read_data, model_head());
        chk({tag, " empty"}, {31'h0, fifo_empty}, {31'h0, model_q.size() == 0});
        chk({tag, " full"}, {31'h0, fifo_full}, {31'h0, model_q.size() == D});
`ifdef SENSOR_FIFO_LEVEL_EN
        chk({tag, " level"}, {28'h0, fifo_level}, 32'(model_q.size()));
`endif
    endtask

    // One clock: drive on the falling edge, update the model from the rules, sample #1 after the rise.
    task automatic step(input bit wr, input logic [31:0] d, input bit rd);
        bit w_ok;
        bit r_ok;
        @(negedge tb_clk);
        write_command = wr;
        write_data    = d;
        read_command  = rd;
        w_ok = wr && (model_q.size() < D);
        r_ok = rd && (model_q.size() > 0);
        @(posedge tb_clk);
        #1;
        if (r_ok) void'(model_q.pop_front());
        if (w_ok) model_q.push_back(d);
        write_command = 1'b0;
        read_command  = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge tb_clk);
        #2;
        n_rst = 1'b0;
        #1;
        model_q.delete();
        chk({tag, " rst empty"}, {31'h0, fifo_empty}, 32'h1);
        chk({tag, " rst full"}, {31'h0, fifo_full}, 32'h0);
        chk({tag, " rst read_data"}, read_data, 32'h0);
`ifdef SENSOR_FIFO_LEVEL_EN
        chk({tag, " rst level"}, {28'h0, fifo_level}, 32'h0);
`endif
        @(negedge tb_clk);
        n_rst = 1'b1;
    endtask

    function automatic vec_t v(bit wr, logic [31:0] d, bit rd, logic [31:0] ed, bit ee, bit ef);
        vec_t r;
        r.wr = wr; r.d = d; r.rd = rd; r.exp_data = ed; r.exp_empty = ee; r.exp_full = ef;
        return r;
    endfunction

    initial begin
        logic [31:0] fill_words[7];
        logic [31:0] w;
        fill_words = '{32'h10101010, 32'hEFEFEFEF, 32'hBADABADA, 32'h45254525,
                       32'hFFFF000F, 32'h001F1EDA, 32'hCAFE0BED};

        tbl.push_back(v(1, 32'h12345678, 0, 32'h12345678, 0, 0));
        tbl.push_back(v(0, 32'h0,        1, 32'h0,        1, 0));
        tbl.push_back(v(1, 32'hAABB1133, 0, 32'hAABB1133, 0, 0));
        tbl.push_back(v(1, 32'h14725896, 0, 32'hAABB1133, 0, 0));
        tbl.push_back(v(1, 32'h53371830, 0, 32'hAABB1133, 0, 0));
        tbl.push_back(v(0, 32'h0,        1, 32'h14725896, 0, 0));
        tbl.push_back(v(0, 32'h0,        1, 32'h53371830, 0, 0));
        tbl.push_back(v(0, 32'h0,        1, 32'h0,        1, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(v(1, fill_words[i], 0, 32'h10101010, 0, 0));
        tbl.push_back(v(1, 32'hDEADBEEF, 0, 32'h10101010, 0, 1));
        tbl.push_back(v(1, 32'h99999999, 0, 32'h10101010, 0, 1));
        // Read+write on full: the pop wins, the new word is lost.
        tbl.push_back(v(1, 32'h77777777, 1, 32'hEFEFEFEF, 0, 0));
        for (int i = 2; i < 7; i++)
            tbl.push_back(v(0, 32'h0, 1, fill_words[i], 0, 0));
        tbl.push_back(v(0, 32'h0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(v(0, 32'h0, 1, 32'h0, 1, 0));
        // Read+write on empty: only the write lands.
        tbl.push_back(v(1, 32'h5A5A5A5A, 1, 32'h5A5A5A5A, 0, 0));
        tbl.push_back(v(0, 32'h0, 1, 32'h0, 1, 0));

        n_rst         = 1'b1;
        write_command = 1'b0;
        write_data    = '0;
        read_command  = 1'b0;
        #1;
        n_rst = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1;
        chk("reset empty", {31'h0, fifo_empty}, 32'h1);
        chk("reset full", {31'h0, fifo_full}, 32'h0);
        chk("reset read_data", read_data, 32'h0);
        @(negedge tb_clk);
        n_rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].rd);
            chk($sformatf("vec%0d read_data", i), read_data, tbl[i].exp_data);
            chk($sformatf("vec%0d empty", i), {31'h0, fifo_empty}, {31'h0, tbl[i].exp_empty});
            chk($sformatf("vec%0d full", i), {31'h0, fifo_full}, {31'h0, tbl[i].exp_full});
        end

        // Fill and drain starting from a non-zero pointer offset.
        pulse_reset("pre-wrap");
        for (int i = 0; i < 3; i++) step(1, 32'hA0000000 + 32'(i), 0);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 1);
        chk("wrap start empty", {31'h0, fifo_empty}, 32'h1);
        for (int i = 0; i < D; i++) step(1, 32'hC0DE0000 + 32'h01010101 * 32'(i), 0);
        chk("wrap full", {31'h0, fifo_full}, 32'h1);
        for (int i = 0; i < D; i++) begin
            w = 32'hC0DE0000 + 32'h01010101 * 32'(i);
            chk($sformatf("wrap head%0d", i), read_data, w);
            step(0, 32'h0, 1);
        end
        chk("wrap end empty", {31'h0, fifo_empty}, 32'h1);
        chk("wrap end full", {31'h0, fifo_full}, 32'h0);
        check_model("wrap end");

        // Reset asserted mid-fill clears everything at once.
        for (int i = 0; i < 5; i++) step(1, 32'hBEEF0000 + 32'(i), 0);
        check_model("midfill");
        pulse_reset("midfill");
        step(0, 32'h0, 0);
        check_model("post reset");

        // Randomized traffic with drifting write/read bias to visit full and empty often.
        for (int c = 0; c < 600; c++) begin
            int wp;
            int rp;
            wp = ((c / 100) % 2 == 0) ? 75 : 30;
            rp = 100 - wp;
            step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp);
            check_model($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
